// File: rtl/inc_pulse_driver.sv
// Transmitting end of the inccomp INCA/INCB interface: turns commands into
// spaced increment pulses and checks the returned max C against shadow counters.
module inc_pulse_driver #(
    parameter int unsigned GAP = 0
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_chan,
    input  logic [7:0] cmd_count,
    output logic       INCA,
    output logic       INCB,
    input  logic [7:0] C,
    output logic [7:0] exp_c,
    output logic       busy,
    output logic       done,
    output logic       mismatch,
    output logic [7:0] err_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] GAP_LOAD = 4'(GAP);

    logic [1:0] r_state;
    logic [1:0] r_chan;
    logic [7:0] r_cnt;
    logic [3:0] r_gap;
    logic       r_inca;
    logic       r_incb;
    logic [7:0] r_sha;
    logic [7:0] r_shb;
    logic       r_mismatch;
    logic [7:0] r_err_cnt;

    logic       w_accept;
    logic [1:0] w_next_state;
    logic [1:0] w_next_chan;
    logic [7:0] w_next_cnt;
    logic [3:0] w_next_gap;

    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    // NOTE: every next-state signal is defaulted to its current value first, so
    // a case arm that leaves one untouched holds it instead of inferring a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_chan  = r_chan;
        w_next_cnt   = r_cnt;
        w_next_gap   = r_gap;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_chan  = cmd_chan;
                    w_next_cnt   = cmd_count;
                    w_next_state = (cmd_count == 8'd0 || cmd_chan == 2'b00) ? S_DONE : S_PULSE;
                end
            end
            S_PULSE: begin
                w_next_cnt = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_next_state = S_DONE;
                end else if (GAP != 0) begin
                    w_next_state = S_GAP;
                    w_next_gap   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (r_gap == 4'd1) begin
                    w_next_state = S_PULSE;
                end else begin
                    w_next_gap = r_gap - 4'd1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order in this block.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_chan     <= 2'b00;
            r_cnt      <= 8'd0;
            r_gap      <= 4'd0;
            r_inca     <= 1'b0;
            r_incb     <= 1'b0;
            r_sha      <= 8'd0;
            r_shb      <= 8'd0;
            r_mismatch <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_chan  <= w_next_chan;
            r_cnt   <= w_next_cnt;
            r_gap   <= w_next_gap;
            // Pulses are decoded from the next state so they line up with PULSE.
            r_inca  <= (w_next_state == S_PULSE) && w_next_chan[0];
            r_incb  <= (w_next_state == S_PULSE) && w_next_chan[1];
            if (r_inca) begin
                r_sha <= r_sha + 8'd1;
            end
            if (r_incb) begin
                r_shb <= r_shb + 8'd1;
            end
            if (C != exp_c) begin
                r_mismatch <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign INCA     = r_inca;
    assign INCB     = r_incb;
    assign exp_c    = (r_sha >= r_shb) ? r_sha : r_shb;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign mismatch = r_mismatch;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_inc_pulse_driver.sv
// Bench for inc_pulse_driver: two lanes (GAP=0 and GAP=2), an inccomp emulator
// closing the loop on C, and a timing-formula model checked every cycle.
module tb_inc_pulse_driver;

    localparam int GAP0   = 0;
    localparam int GAP1   = 2;
    localparam int BUDGET = 2000;

    logic            ck = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      cmd_valid = '0;
    logic [1:0][1:0] cmd_chan = '0;
    logic [1:0][7:0] cmd_count = '0;
    logic [1:0]      cmd_ready;
    logic [1:0]      inca;
    logic [1:0]      incb;
    logic [1:0]      busy;
    logic [1:0]      done;
    logic [1:0]      mismatch;
    logic [1:0][7:0] exp_c;
    logic [1:0][7:0] err_cnt;
    logic [1:0][7:0] c_in;
    logic [1:0][7:0] c_emu = '0;
    logic [1:0]      force_en = '0;
    logic [7:0]      force_val = '0;

    always #5 ck = ~ck;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        assign c_in[g] = force_en[g] ? force_val : c_emu[g];
        inc_pulse_driver #(.GAP((g == 0) ? GAP0 : GAP1)) u_dut (
            .ck        (ck),
            .rst       (rst),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_chan  (cmd_chan[g]),
            .cmd_count (cmd_count[g]),
            .INCA      (inca[g]),
            .INCB      (incb[g]),
            .C         (c_in[g]),
            .exp_c     (exp_c[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .mismatch  (mismatch[g]),
            .err_cnt   (err_cnt[g])
        );
    end

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;
    int cyc     = 0;

    // Reference model: command timing from the closed-form schedule.
    bit         act  [2];
    int         e0   [2];
    int         m_n  [2];
    logic [1:0] m_ch [2];
    logic [7:0] m_sa [2];
    logic [7:0] m_sb [2];
    logic [7:0] m_err[2];
    bit         m_mm [2];

    // inccomp emulator, fed by DUT pulses sampled mid-cycle.
    logic [7:0] ea    [2];
    logic [7:0] eb    [2];
    logic [7:0] c_next[2];
    logic [1:0] s_inca = '0;
    logic [1:0] s_incb = '0;

    // Observations per lane, relative to the accept edge.
    bit acc_seen  [2];
    int acc_e0    [2];
    bit done_seen [2];
    int obs_done  [2];
    int obs_pulses[2];
    int obs_both  [2];
    int obs_first [2];
    int obs_last  [2];

    function automatic int gap_of(int l);
        return (l == 0) ? GAP0 : GAP1;
    endfunction

    function automatic bit trivial(int l);
        return (m_n[l] == 0) || (m_ch[l] == 2'b00);
    endfunction

    function automatic int done_rel(int l);
        return trivial(l) ? 1 : 2 + (m_n[l] - 1) * (gap_of(l) + 1);
    endfunction

    function automatic bit m_busy(int l, int c);
        int r = c - e0[l];
        return act[l] && (r >= 1) && (r <= done_rel(l));
    endfunction

    function automatic bit m_done(int l, int c);
        return act[l] && ((c - e0[l]) == done_rel(l));
    endfunction

    function automatic bit m_pulse(int l, int c);
        int r = c - e0[l] - 1;
        int p = gap_of(l) + 1;
        return act[l] && !trivial(l) && (r >= 0) && ((r % p) == 0) && ((r / p) < m_n[l]);
    endfunction

    function automatic logic [7:0] max8(logic [7:0] a, logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic compare_all();
        for (int l = 0; l < 2; l++) begin
            check($sformatf("cmd_ready[%0d]", l), 32'(cmd_ready[l]), 32'(!rst && !m_busy(l, cyc)));
            check($sformatf("INCA[%0d]", l), 32'(inca[l]), 32'(m_pulse(l, cyc) && m_ch[l][0]));
            check($sformatf("INCB[%0d]", l), 32'(incb[l]), 32'(m_pulse(l, cyc) && m_ch[l][1]));
            check($sformatf("busy[%0d]", l), 32'(busy[l]), 32'(m_busy(l, cyc)));
            check($sformatf("done[%0d]", l), 32'(done[l]), 32'(m_done(l, cyc)));
            check($sformatf("exp_c[%0d]", l), 32'(exp_c[l]), 32'(max8(m_sa[l], m_sb[l])));
            check($sformatf("mismatch[%0d]", l), 32'(mismatch[l]), 32'(m_mm[l]));
            check($sformatf("err_cnt[%0d]", l), 32'(err_cnt[l]), 32'(m_err[l]));
        end
    endtask

    task automatic observe();
        for (int l = 0; l < 2; l++) begin
            if (cmd_valid[l] && cmd_ready[l]) begin
                acc_seen[l] = 1'b1;
                acc_e0[l]   = cyc;
            end
            if (inca[l] || incb[l]) begin
                obs_pulses[l]++;
                if (obs_first[l] < 0) obs_first[l] = cyc - acc_e0[l];
                obs_last[l] = cyc - acc_e0[l];
            end
            if (inca[l] && incb[l]) obs_both[l]++;
            if (done[l]) begin
                done_seen[l] = 1'b1;
                obs_done[l]  = cyc - acc_e0[l];
            end
        end
    endtask

    task automatic model_edge();
        for (int l = 0; l < 2; l++) begin
            if (rst) begin
                act[l]    = 1'b0;
                m_sa[l]   = 8'd0;
                m_sb[l]   = 8'd0;
                m_err[l]  = 8'd0;
                m_mm[l]   = 1'b0;
                ea[l]     = 8'd0;
                eb[l]     = 8'd0;
                c_next[l] = 8'd0;
            end else begin
                if (c_in[l] != max8(m_sa[l], m_sb[l])) begin
                    m_mm[l] = 1'b1;
                    if (m_err[l] != 8'd255) m_err[l] = m_err[l] + 8'd1;
                end
                if (m_pulse(l, cyc)) begin
                    if (m_ch[l][0]) m_sa[l] = m_sa[l] + 8'd1;
                    if (m_ch[l][1]) m_sb[l] = m_sb[l] + 8'd1;
                end
                if (cmd_valid[l] && !m_busy(l, cyc)) begin
                    act[l]  = 1'b1;
                    e0[l]   = cyc;
                    m_n[l]  = int'(cmd_count[l]);
                    m_ch[l] = cmd_chan[l];
                end
                ea[l]     = ea[l] + {7'd0, s_inca[l]};
                eb[l]     = eb[l] + {7'd0, s_incb[l]};
                c_next[l] = max8(ea[l], eb[l]);
            end
        end
        cyc++;
    endtask

    // One clock cycle: check mid-cycle, advance the model on the edge, then let
    // the emulated inccomp present its registered C just after the edge.
    task automatic tick();
        @(negedge ck);
        s_inca = inca;
        s_incb = incb;
        if (chk_en) compare_all();
        observe();
        @(posedge ck);
        model_edge();
        #1;
        c_emu[0] = c_next[0];
        c_emu[1] = c_next[1];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input int l, input logic [1:0] ch, input logic [7:0] cnt);
        int t = 0;
        acc_seen[l]   = 1'b0;
        done_seen[l]  = 1'b0;
        obs_pulses[l] = 0;
        obs_both[l]   = 0;
        obs_first[l]  = -1;
        obs_last[l]   = -1;
        obs_done[l]   = -1;
        cmd_chan[l]   = ch;
        cmd_count[l]  = cnt;
        cmd_valid[l]  = 1'b1;
        while (!acc_seen[l] && t < BUDGET) begin
            tick();
            t++;
        end
        cmd_valid[l] = 1'b0;
        check($sformatf("accepted[%0d]", l), 32'(acc_seen[l]), 32'd1);
    endtask

    task automatic wait_done(input int l);
        int t = 0;
        while (!done_seen[l] && t < BUDGET) begin
            tick();
            t++;
        end
        check($sformatf("done_seen[%0d]", l), 32'(done_seen[l]), 32'd1);
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;

        tick();
        check("idle_ready", 32'(cmd_ready), 32'd3);
        check("idle_pulses", 32'({inca, incb}), 32'd0);
        check("idle_busy_done", 32'({busy, done}), 32'd0);
        check("idle_exp_c", 32'(exp_c[0]), 32'd0);
        check("idle_mismatch", 32'(mismatch), 32'd0);
        repeat (3) tick();

        send(0, 2'b01, 8'd3);
        wait_done(0);
        check("a3_done_rel", 32'(obs_done[0]), 32'd4);
        check("a3_pulses", 32'(obs_pulses[0]), 32'd3);
        check("a3_first", 32'(obs_first[0]), 32'd1);
        check("a3_last", 32'(obs_last[0]), 32'd3);
        send(0, 2'b10, 8'd5);
        wait_done(0);
        check("b5_done_rel", 32'(obs_done[0]), 32'd6);
        check("b5_exp_c", 32'(exp_c[0]), 32'd5);
        check("b5_c", 32'(c_in[0]), 32'd5);
        check("b5_err_cnt", 32'(err_cnt[0]), 32'd0);

        do_reset();
        send(0, 2'b01, 8'd255);
        wait_done(0);
        check("wrap_255", 32'(exp_c[0]), 32'd255);
        send(0, 2'b01, 8'd2);
        wait_done(0);
        check("wrap_to_1", 32'(exp_c[0]), 32'd1);
        send(0, 2'b10, 8'd10);
        wait_done(0);
        check("wrap_max", 32'(exp_c[0]), 32'd10);
        check("wrap_mismatch", 32'(mismatch[0]), 32'd0);

        send(1, 2'b11, 8'd4);
        wait_done(1);
        check("gap_done_rel", 32'(obs_done[1]), 32'd11);
        check("gap_pulses", 32'(obs_pulses[1]), 32'd4);
        check("gap_both", 32'(obs_both[1]), 32'd4);
        check("gap_first", 32'(obs_first[1]), 32'd1);
        check("gap_last", 32'(obs_last[1]), 32'd10);
        check("gap_exp_c", 32'(exp_c[1]), 32'd4);

        send(0, 2'b01, 8'd0);
        wait_done(0);
        check("cnt0_done_rel", 32'(obs_done[0]), 32'd1);
        check("cnt0_pulses", 32'(obs_pulses[0]), 32'd0);
        send(0, 2'b00, 8'd7);
        wait_done(0);
        check("chan0_done_rel", 32'(obs_done[0]), 32'd1);
        check("chan0_pulses", 32'(obs_pulses[0]), 32'd0);

        send(0, 2'b01, 8'd100);
        repeat (18) tick();
        do_reset();
        repeat (3) tick();
        check("abort_no_done", 32'(done_seen[0]), 32'd0);
        check("abort_exp_c", 32'(exp_c[0]), 32'd0);
        check("abort_c", 32'(c_in[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);

        send(0, 2'b10, 8'd5);
        wait_done(0);
        check("fault_pre_exp_c", 32'(exp_c[0]), 32'd5);
        force_val   = 8'h00;
        force_en[0] = 1'b1;
        repeat (3) tick();
        force_en[0] = 1'b0;
        check("fault_mismatch", 32'(mismatch[0]), 32'd1);
        check("fault_err_cnt", 32'(err_cnt[0]), 32'd3);
        repeat (5) tick();
        check("fault_hold_mismatch", 32'(mismatch[0]), 32'd1);
        check("fault_hold_err_cnt", 32'(err_cnt[0]), 32'd3);
        force_en[0] = 1'b1;
        repeat (300) tick();
        force_en[0] = 1'b0;
        tick();
        check("fault_saturate", 32'(err_cnt[0]), 32'd255);
        do_reset();
        check("fault_clr_mismatch", 32'(mismatch[0]), 32'd0);
        check("fault_clr_err_cnt", 32'(err_cnt[0]), 32'd0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
